sun_pll_ctrl: RTL



---
 rtl/sun_pll_ctrl_pkg.sv | 26 ++
 rtl/sun_pll_edge_sync.sv | 22 ++
 rtl/sun_pll_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sun_pll_ctrl_pkg.sv
// Shared types and defaults for the PLL power-up sequencer and lock monitor.
package sun_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  localparam int unsigned DEF_SETTLE_CYC   = 1024;
  localparam int unsigned DEF_WIN          = 64;
  localparam int unsigned DEF_TOL          = 1;
  localparam int unsigned DEF_LOCK_WINS    = 4;
  localparam int unsigned DEF_TIMEOUT_WINS = 64;
  localparam int unsigned DEF_REF_WD       = 4096;
  localparam int unsigned DEF_CW           = 8;

  // A window passes when its feedback count lies within win +/- tol.
  function automatic logic win_pass(input int unsigned f, input int unsigned win,
                                    input int unsigned tol);
    return ((f + tol) >= win) && (f <= (win + tol));
  endfunction

endpackage

// File: rtl/sun_pll_edge_sync.sv
// Two-flop synchronizer for an asynchronous clock input, plus a third flop
// that turns each rising edge into a one-cycle pulse.
module sun_pll_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_c_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_c_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sun_pll_ctrl.sv
// PLL power-up sequencer and frequency-lock monitor; runs on the always-on
// clock and counts CK_FB edges over windows of WIN CK_REF edges.
module sun_pll_ctrl
  import sun_pll_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int unsigned WIN          = DEF_WIN,
  parameter int unsigned TOL          = DEF_TOL,
  parameter int unsigned LOCK_WINS    = DEF_LOCK_WINS,
  parameter int unsigned TIMEOUT_WINS = DEF_TIMEOUT_WINS,
  parameter int unsigned REF_WD       = DEF_REF_WD,
  parameter int unsigned CW           = DEF_CW
) (
  input  logic          CK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          CK_REF,
  input  logic          CK_FB,
  output logic          PWRUP_1V8,
  output logic          LOCKED,
  output logic          FAIL,
  output logic [CW-1:0] FB_CNT,
  output logic [2:0]    STATE
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned PW = $clog2(LOCK_WINS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_WINS + 1);
  localparam int unsigned WW = $clog2(REF_WD + 1);

  state_e        state_q, state_d;
  logic          pwrup_q, pwrup_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic [CW-1:0] fb_cnt_q, fb_cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          win_open_q, win_open_d;
  logic [CW-1:0] ref_cnt_q, ref_cnt_d;
  logic [CW-1:0] fb_acc_q, fb_acc_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [WW-1:0] wd_q, wd_d;

  logic          ref_p;
  logic          fb_p;
  logic          measuring_c;
  logic [CW-1:0] fb_inc_c;
  logic          win_close_c;
  logic          win_pass_c;

  sun_pll_edge_sync u_ref_sync (
    .clk_i    (CK),
    .rst_ni   (RST_N),
    .d_i      (CK_REF),
    .rise_c_o (ref_p)
  );

  sun_pll_edge_sync u_fb_sync (
    .clk_i    (CK),
    .rst_ni   (RST_N),
    .d_i      (CK_FB),
    .rise_c_o (fb_p)
  );

  // Feedback count including this cycle's edge, saturating at all-ones.
  always_comb begin
    fb_inc_c = fb_acc_q;
    if (fb_p && (fb_acc_q != '1)) begin
      fb_inc_c = fb_acc_q + CW'(1);
    end
  end

  assign measuring_c = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
  assign win_close_c = measuring_c && win_open_q && ref_p && (ref_cnt_q == CW'(WIN - 1));
  assign win_pass_c  = win_pass(32'(fb_inc_c), WIN, TOL);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    fb_cnt_d   = fb_cnt_q;
    settle_d   = settle_q;
    win_open_d = win_open_q;
    ref_cnt_d  = ref_cnt_q;
    fb_acc_d   = fb_acc_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    wd_d       = wd_q;
    pwrup_d    = 1'b0;
    locked_d   = 1'b0;
    fail_d     = 1'b0;

    // The closing reference edge also starts the next window, uncounted.
    if (measuring_c) begin
      if (!win_open_q) begin
        if (ref_p) begin
          win_open_d = 1'b1;
          ref_cnt_d  = '0;
          fb_acc_d   = '0;
        end
      end else if (win_close_c) begin
        ref_cnt_d = '0;
        fb_acc_d  = '0;
        fb_cnt_d  = fb_inc_c;
      end else begin
        fb_acc_d = fb_inc_c;
        if (ref_p) begin
          ref_cnt_d = ref_cnt_q + CW'(1);
        end
      end
      wd_d = ref_p ? '0 : wd_q + WW'(1);
    end

    case (state_q)
      ST_OFF: begin
        if (EN) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          pass_d   = '0;
          tmo_d    = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d    = ST_MEASURE;
          win_open_d = 1'b0;
          ref_cnt_d  = '0;
          fb_acc_d   = '0;
          wd_d       = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_MEASURE: begin
        if (win_close_c) begin
          tmo_d  = tmo_q + TW'(1);
          pass_d = win_pass_c ? pass_q + PW'(1) : '0;
          if (win_pass_c && (pass_q == PW'(LOCK_WINS - 1))) begin
            state_d = ST_LOCKED;
          end else if (tmo_q == TW'(TIMEOUT_WINS - 1)) begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_LOCKED: begin
        if (win_close_c && !win_pass_c) begin
          state_d = ST_MEASURE;
          pass_d  = '0;
          tmo_d   = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Reference watchdog overrides any window outcome.
    if (measuring_c && !ref_p && (wd_q == WW'(REF_WD - 1))) begin
      state_d = ST_FAIL;
    end

    // Dropping EN abandons everything, including a partial window.
    if (!EN) begin
      state_d    = ST_OFF;
      fb_cnt_d   = '0;
      settle_d   = '0;
      win_open_d = 1'b0;
      ref_cnt_d  = '0;
      fb_acc_d   = '0;
      pass_d     = '0;
      tmo_d      = '0;
      wd_d       = '0;
    end

    pwrup_d  = (state_d == ST_SETTLE) || (state_d == ST_MEASURE) || (state_d == ST_LOCKED);
    locked_d = (state_d == ST_LOCKED);
    fail_d   = (state_d == ST_FAIL);
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_q    <= ST_OFF;
      pwrup_q    <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      fb_cnt_q   <= '0;
      settle_q   <= '0;
      win_open_q <= 1'b0;
      ref_cnt_q  <= '0;
      fb_acc_q   <= '0;
      pass_q     <= '0;
      tmo_q      <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      pwrup_q    <= pwrup_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      fb_cnt_q   <= fb_cnt_d;
      settle_q   <= settle_d;
      win_open_q <= win_open_d;
      ref_cnt_q  <= ref_cnt_d;
      fb_acc_q   <= fb_acc_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      wd_q       <= wd_d;
    end
  end

  assign PWRUP_1V8 = pwrup_q;
  assign LOCKED    = locked_q;
  assign FAIL      = fail_q;
  assign FB_CNT    = fb_cnt_q;
  assign STATE     = state_q;

endmodule
